aes_iter_core: RTL and testbench
================================

AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 Parameter KEY_L, default 128, cipher key length in bits; legal values 128 or 256, any other value SHALL fail elaboration.
REQ-002 Parameter DATA_W, default 128, block width in bits; fixed at 128, any other value SHALL fail elaboration.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  plain_text and cipher_key are valid.
REQ-006 in_ready  output  1  core can accept a block this cycle.
REQ-007 cipher_key  input  KEY_L  cipher key, byte 0 in the MSBs (FIPS-197 order).
REQ-008 plain_text  input  DATA_W  plaintext block, byte 0 in the MSBs.
REQ-009 cipher_text  output  DATA_W  ciphertext, registered.
REQ-010 out_valid  output  1  cipher_text holds a finished block.
REQ-011 out_ready  input  1  consumer accepts cipher_text this cycle.

Function
REQ-012 The core SHALL be iterative, running one AES encryption round per clock, with Nr = 10 for KEY_L=128 and Nr = 14 for KEY_L=256.
REQ-013 The FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-014 Accept means in_valid & in_ready at a rising edge; on accept the core SHALL latch cipher_key, load state = plain_text ^ round key 0, clear round_cnt to 1 and enter ROUND.
REQ-015 In ROUND, each edge SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey, omitting MixColumns when round_cnt == Nr, then increment round_cnt.
REQ-016 On the edge that completes round Nr, the core SHALL write cipher_text and enter DONE, with out_valid = 1; latency is exactly Nr clocks from the accept edge to out_valid high.
REQ-017 The round key SHALL be expanded on the fly, one 128-bit round key per clock.
REQ-018 For KEY_L=256, round keys 0 and 1 SHALL be the two key halves, and later keys SHALL alternate RotWord+SubWord+Rcon steps with SubWord-only steps.
REQ-019 Rcon SHALL be a register initialised to 0x01 and updated by xtime.
REQ-020 in_ready SHALL be 1 in IDLE, 0 in ROUND, and equal to out_ready in DONE.
REQ-021 In DONE with out_ready = 1 and in_valid = 0, the core SHALL return to IDLE.
REQ-022 In DONE with out_ready = 1 and in_valid = 1, the core SHALL accept the new block in the same cycle, with no bubble.
REQ-023 In DONE with out_ready = 0, cipher_text and out_valid SHALL hold stable, and inputs SHALL be ignored.
REQ-024 cipher_text SHALL hold its last value after the handshake until the next completion.
REQ-025 Changes on cipher_key or plain_text after the accept edge SHALL have no effect on the in-flight block.
REQ-026 out_valid SHALL be a registered output, not decoded combinationally from inputs.

Reset
REQ-027 Assertion of reset SHALL at once force state IDLE, out_valid = 0, cipher_text = 0, round_cnt = 0, state and key registers = 0, and Rcon = 0x01.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight block, with no output produced for it.
REQ-029 in_ready SHALL be 1 from the first edge after reset deasserts.

Structure
REQ-030 The shared package SHALL hold the S-box table, the xtime function, the FSM state enum and the Nr derivation from KEY_L.
REQ-031 Sub-module aes_key_step SHALL produce the next round key from the current key words, Rcon and a step-type select; all else is in aes_iter_core.

Verification
REQ-032 Reset, then send KEY_L=128 with key 2b7e151628aed2a6abf7158809cf4f3c and pt 3243f6a8885a308d313198a2e0370734 -> cipher_text 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 clocks after accept.
REQ-033 KEY_L=256 with key 000102..1f and pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089 after 14 clocks.
REQ-034 KEY_L=128 with key 000102..0f, same pt, and out_ready held 0 for 5 cycles -> 69c4e0d86a7b0430d8cdb78070b4c55a, stable with out_valid = 1 throughout; in_ready = 0 and in_valid ignored until release.
REQ-035 Back-to-back: second block presented with in_valid = 1 during DONE and out_ready = 1 -> accepted that cycle, results in order, accept-to-accept spacing 11 clocks (KEY_L=128).
REQ-036 Assert reset at round 5, then send a new block -> out_valid stays 0, outputs are 0, and the next block gives the correct ciphertext with full latency.
REQ-037 Change plain_text and cipher_key every cycle while in ROUND -> result matches the values latched at accept.

Source files
------------

// File: rtl/aes_iter_core_pkg.sv
// Shared AES definitions: S-box, GF(2^8) doubling, FSM encoding and round-count derivation.
package aes_iter_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nr_of(input int key_l);
        return (key_l == 256) ? 14 : 10;
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block handshake bundle: key/plaintext in with valid/ready, ciphertext out with valid/ready.
interface aes_iter_core_if #(
    parameter int KEY_L  = 128,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [KEY_L-1:0]  cipher_key;
    logic [DATA_W-1:0] plain_text;
    logic [DATA_W-1:0] cipher_text;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_valid, cipher_key, plain_text, out_ready,
        input  in_ready, cipher_text, out_valid
    );

    modport slave (
        input  in_valid, cipher_key, plain_text, out_ready,
        output in_ready, cipher_text, out_valid
    );
endinterface

// File: rtl/aes_key_step.sv
// One key-expansion step: derives the next 128-bit round key from four earlier words.
module aes_key_step
    import aes_iter_core_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [31:0]  last_word,
    input  logic [7:0]   rcon,
    input  logic         rot_step,
    output logic [127:0] next_key
);
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] temp;
    logic [31:0] w0, w1, w2, w3;

    always_comb begin
        rot_word = rot_step ? {last_word[23:0], last_word[31:24]} : last_word;
        sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
        temp     = rot_step ? (sub_word ^ {rcon, 24'h000000}) : sub_word;
        w0       = prev_key[127:96] ^ temp;
        w1       = prev_key[95:64]  ^ w0;
        w2       = prev_key[63:32]  ^ w1;
        w3       = prev_key[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    end
endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: one round per clock, round keys expanded alongside the data path.
//   state | meaning
//   IDLE  | waiting for a block (ready once out of reset)
//   ROUND | applying rounds 1..Nr, inputs ignored
//   DONE  | cipher_text valid, held until out_ready
module aes_iter_core
    import aes_iter_core_pkg::*;
#(
    parameter int KEY_L  = 128,
    parameter int DATA_W = 128
) (
    input logic            clk,
    input logic            reset,
    aes_iter_core_if.slave bus
);
    if (KEY_L != 128 && KEY_L != 256) begin : g_bad_key
        $fatal(1, "aes_iter_core: KEY_L must be 128 or 256");
    end
    if (DATA_W != 128) begin : g_bad_data
        $fatal(1, "aes_iter_core: DATA_W must be 128");
    end

    localparam int         NR     = nr_of(KEY_L);
    localparam logic [3:0] NR_CNT = 4'(NR);

    state_t             fsm_q;
    logic [3:0]         round_cnt;
    logic [127:0]       state_q;
    logic [KEY_L-1:0]   key_q;
    logic [7:0]         rcon_q;
    logic [DATA_W-1:0]  cipher_q;
    logic               out_valid_q;
    logic               run_q;
    logic               in_ready;
    logic               accept;

    logic [127:0]       step_prev;
    logic [31:0]        step_last;
    logic               step_rot;
    logic [127:0]       step_key;
    logic [127:0]       round_key;
    logic [KEY_L-1:0]   key_next;
    logic               rcon_adv;
    logic [127:0]       round_mid;
    logic [127:0]       state_next;

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Byte 0 sits in the MSBs; byte index is 4*column + row.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c + rw) % 4) + rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    // AES-128 derives round key r from key r-1 in the same cycle; AES-256 keeps a
    // two-key window (r-1, r) and precomputes key r+1, alternating step types.
    if (KEY_L == 128) begin : g_ks128
        always_comb begin
            step_prev = key_q;
            step_last = key_q[31:0];
            step_rot  = 1'b1;
            round_key = step_key;
            key_next  = step_key;
            rcon_adv  = 1'b1;
        end
    end else begin : g_ks256
        always_comb begin
            step_prev = key_q[255:128];
            step_last = key_q[31:0];
            step_rot  = round_cnt[0];
            round_key = key_q[127:0];
            key_next  = {key_q[127:0], step_key};
            rcon_adv  = round_cnt[0];
        end
    end

    aes_key_step u_key_step (
        .prev_key  (step_prev),
        .last_word (step_last),
        .rcon      (rcon_q),
        .rot_step  (step_rot),
        .next_key  (step_key)
    );

    always_comb begin
        round_mid  = shift_rows(sub_bytes(state_q));
        state_next = ((round_cnt == NR_CNT) ? round_mid : mix_columns(round_mid)) ^ round_key;
    end

    always_comb begin
        in_ready = 1'b0;
        case (fsm_q)
            IDLE:    in_ready = run_q;
            DONE:    in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept          = bus.in_valid & in_ready;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.cipher_text = cipher_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            round_cnt   <= 4'd0;
            state_q     <= '0;
            key_q       <= '0;
            rcon_q      <= 8'h01;
            cipher_q    <= '0;
            out_valid_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                key_q       <= bus.cipher_key;
                state_q     <= bus.plain_text ^ bus.cipher_key[KEY_L-1 -: 128];
                round_cnt   <= 4'd1;
                rcon_q      <= 8'h01;
                out_valid_q <= 1'b0;
                fsm_q       <= ROUND;
            end else begin
                case (fsm_q)
                    ROUND: begin
                        state_q   <= state_next;
                        key_q     <= key_next;
                        round_cnt <= round_cnt + 4'd1;
                        if (rcon_adv) rcon_q <= xtime(rcon_q);
                        if (round_cnt == NR_CNT) begin
                            cipher_q    <= state_next;
                            out_valid_q <= 1'b1;
                            fsm_q       <= DONE;
                        end
                    end
                    DONE: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            fsm_q       <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed-vector bench for aes_iter_core with AES-128 and AES-256 instances.
module tb_aes_iter_core;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_FIPS  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_FIPS  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_SEQ   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_SEQ   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K_SEQ256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C_SEQ256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_iter_core_if #(.KEY_L(128), .DATA_W(128)) bus128 ();
    aes_iter_core_if #(.KEY_L(256), .DATA_W(128)) bus256 ();

    aes_iter_core #(.KEY_L(128), .DATA_W(128)) dut128 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus128.slave)
    );

    aes_iter_core #(.KEY_L(256), .DATA_W(128)) dut256 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus256.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge: presents one block, waits for completion (bounded).
    // lat = edges from accept to out_valid, 99 on timeout; scramble churns inputs meanwhile.
    task automatic run128(input logic [127:0] key, input logic [127:0] pt, input bit scramble,
                          output logic [127:0] ct, output int lat, output int acc_cyc);
        bus128.cipher_key = key;
        bus128.plain_text = pt;
        bus128.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        bus128.in_valid = scramble;
        lat = 0;
        while (bus128.out_valid !== 1'b1 && lat < 40) begin
            if (scramble) begin
                bus128.cipher_key = {$urandom, $urandom, $urandom, $urandom};
                bus128.plain_text = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus128.out_valid !== 1'b1) lat = 99;
        bus128.in_valid = 1'b0;
        ct = bus128.cipher_text;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid128 got=%b want=0", bus128.out_valid); end
        total++; if (bus128.cipher_text !== 128'h0) begin bad++; $display("FAIL reset_cipher128 got=%h want=0", bus128.cipher_text); end
        total++; if (bus256.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid256 got=%b want=0", bus256.out_valid); end
        total++; if (bus256.cipher_text !== 128'h0) begin bad++; $display("FAIL reset_cipher256 got=%h want=0", bus256.cipher_text); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready128 got=%b want=1", bus128.in_ready); end
        total++; if (bus256.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready256 got=%b want=1", bus256.in_ready); end
    endtask

    task automatic test_fips128();
        logic [127:0] ct;
        int lat, acc;
        run128(K_FIPS, P_FIPS, 1'b0, ct, lat, acc);
        total++; if (ct !== C_FIPS) begin bad++; $display("FAIL fips128_ct got=%h want=%h", ct, C_FIPS); end
        total++; if (lat !== 10) begin bad++; $display("FAIL fips128_latency got=%0d want=10", lat); end
        @(posedge clk);
        @(negedge clk);
        total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL fips128_idle_valid got=%b want=0", bus128.out_valid); end
        total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL fips128_idle_ready got=%b want=1", bus128.in_ready); end
        total++; if (bus128.cipher_text !== C_FIPS) begin bad++; $display("FAIL fips128_hold got=%h want=%h", bus128.cipher_text, C_FIPS); end
    endtask

    task automatic test_aes256();
        int lat;
        bus256.cipher_key = K_SEQ256;
        bus256.plain_text = P_SEQ;
        bus256.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus256.in_valid = 1'b0;
        lat = 0;
        while (bus256.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus256.out_valid !== 1'b1) lat = 99;
        total++; if (bus256.cipher_text !== C_SEQ256) begin bad++; $display("FAIL aes256_ct got=%h want=%h", bus256.cipher_text, C_SEQ256); end
        total++; if (lat !== 14) begin bad++; $display("FAIL aes256_latency got=%0d want=14", lat); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [127:0] ct;
        int lat, acc;
        bus128.out_ready = 1'b0;
        run128(K_SEQ, P_SEQ, 1'b0, ct, lat, acc);
        total++; if (ct !== C_SEQ) begin bad++; $display("FAIL bp_ct got=%h want=%h", ct, C_SEQ); end
        total++; if (lat !== 10) begin bad++; $display("FAIL bp_latency got=%0d want=10", lat); end
        for (int i = 0; i < 5; i++) begin
            bus128.in_valid   = 1'b1;
            bus128.cipher_key = {$urandom, $urandom, $urandom, $urandom};
            bus128.plain_text = {$urandom, $urandom, $urandom, $urandom};
            total++; if (bus128.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_%0d got=%b want=1", i, bus128.out_valid); end
            total++; if (bus128.cipher_text !== C_SEQ) begin bad++; $display("FAIL bp_stable_%0d got=%h want=%h", i, bus128.cipher_text, C_SEQ); end
            total++; if (bus128.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_%0d got=%b want=0", i, bus128.in_ready); end
            @(posedge clk);
            @(negedge clk);
        end
        total++; if (bus128.cipher_text !== C_SEQ) begin bad++; $display("FAIL bp_stable_end got=%h want=%h", bus128.cipher_text, C_SEQ); end
        total++; if (bus128.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_end got=%b want=1", bus128.out_valid); end
        bus128.in_valid  = 1'b0;
        bus128.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", bus128.out_valid); end
        total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bus128.in_ready); end
        total++; if (bus128.cipher_text !== C_SEQ) begin bad++; $display("FAIL bp_release_hold got=%h want=%h", bus128.cipher_text, C_SEQ); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct_a, ct_b;
        int lat_a, lat_b, acc_a, acc_b;
        bus128.out_ready = 1'b1;
        run128(K_FIPS, P_FIPS, 1'b0, ct_a, lat_a, acc_a);
        total++; if (ct_a !== C_FIPS) begin bad++; $display("FAIL b2b_first_ct got=%h want=%h", ct_a, C_FIPS); end
        total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_done_ready got=%b want=1", bus128.in_ready); end
        run128(K_SEQ, P_SEQ, 1'b0, ct_b, lat_b, acc_b);
        total++; if (acc_b - acc_a !== 11) begin bad++; $display("FAIL b2b_spacing got=%0d want=11", acc_b - acc_a); end
        total++; if (ct_b !== C_SEQ) begin bad++; $display("FAIL b2b_second_ct got=%h want=%h", ct_b, C_SEQ); end
        total++; if (lat_b !== 10) begin bad++; $display("FAIL b2b_second_latency got=%0d want=10", lat_b); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct;
        int lat, acc;
        bit seen;
        bus128.cipher_key = K_FIPS;
        bus128.plain_text = P_FIPS;
        bus128.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus128.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus128.out_valid); end
        total++; if (bus128.cipher_text !== 128'h0) begin bad++; $display("FAIL midrst_ct got=%h want=0", bus128.cipher_text); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", bus128.in_ready); end
        seen = 1'b0;
        repeat (15) begin
            if (bus128.out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_output got=%b want=0", seen); end
        total++; if (bus128.cipher_text !== 128'h0) begin bad++; $display("FAIL midrst_ct_zero got=%h want=0", bus128.cipher_text); end
        run128(K_SEQ, P_SEQ, 1'b0, ct, lat, acc);
        total++; if (ct !== C_SEQ) begin bad++; $display("FAIL midrst_next_ct got=%h want=%h", ct, C_SEQ); end
        total++; if (lat !== 10) begin bad++; $display("FAIL midrst_next_latency got=%0d want=10", lat); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_input_change();
        logic [127:0] ct;
        int lat, acc;
        run128(K_FIPS, P_FIPS, 1'b1, ct, lat, acc);
        total++; if (ct !== C_FIPS) begin bad++; $display("FAIL churn_ct got=%h want=%h", ct, C_FIPS); end
        total++; if (lat !== 10) begin bad++; $display("FAIL churn_latency got=%0d want=10", lat); end
        @(posedge clk);
        @(negedge clk);
        total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL churn_idle got=%b want=0", bus128.out_valid); end
    endtask

    initial begin
        bus128.in_valid   = 1'b0;
        bus128.out_ready  = 1'b1;
        bus128.cipher_key = '0;
        bus128.plain_text = '0;
        bus256.in_valid   = 1'b0;
        bus256.out_ready  = 1'b1;
        bus256.cipher_key = '0;
        bus256.plain_text = '0;

        test_reset();
        test_fips128();
        test_aes256();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_input_change();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
